// File: rtl/dc_upload.sv
// Serialises a 144-bit data-cache message into 3 (short) or 9 (long) 16-bit flits for the OUT fifo.
// Optional macro DC_UPLOAD_CLR_EN clears the message buffer when the tail flit is accepted.
module dc_upload #(
  parameter logic [4:0] wbrep_cmd    = 5'b10000,
  parameter logic [4:0] flushrep_cmd = 5'b10010,
  parameter logic [4:0] ATflurep_cmd = 5'b10011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_dc_upload,
  input  logic [143:0] dc_upload_flits,
  input  logic         OUT_fifo_rdy,
  output logic         dc_upload_ack,
  output logic         v_flit_out,
  output logic [15:0]  flit_out,
  output logic [1:0]   flit_ctrl_out,
  output logic         dc_upload_done,
  output logic [1:0]   dc_upload_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_RSV2 = 2'b10,
    S_RSV3 = 2'b11
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [143:0]   r_buf;
  logic [3:0]     r_cnt;
  logic [3:0]     r_len;
  logic [4:0]     w_cmd;
  logic           w_long;
  logic           w_tail;
  logic           w_acc;
  logic [15:0]    w_sel;

  assign w_cmd  = dc_upload_flits[9:5];
  assign w_long = (w_cmd == wbrep_cmd) || (w_cmd == flushrep_cmd) || (w_cmd == ATflurep_cmd);
  assign w_tail = (r_cnt == (r_len - 4'd1));
  assign dc_upload_state = r_state;

  always_comb begin
    w_sel = r_buf[15:0];
    for (int i = 0; i < 9; i++) begin
      if (r_cnt == i[3:0]) w_sel = r_buf[16*i +: 16];
    end
  end

  always_comb begin
    w_next         = r_state;
    dc_upload_ack  = 1'b0;
    v_flit_out     = 1'b0;
    flit_ctrl_out  = 2'b00;
    dc_upload_done = 1'b0;
    w_acc          = 1'b0;
    flit_out       = r_buf[15:0];
    case (r_state)
      S_IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        dc_upload_ack = v_dc_upload & rst;
        if (v_dc_upload) w_next = S_BUSY;
      end
      S_BUSY: begin
        v_flit_out     = 1'b1;
        flit_out       = w_sel;
        flit_ctrl_out  = (r_cnt == 4'd0) ? 2'b01 : (w_tail ? 2'b11 : 2'b10);
        w_acc          = OUT_fifo_rdy;
        dc_upload_done = OUT_fifo_rdy & w_tail;
        if (dc_upload_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_cnt   <= 4'd0;
      r_len   <= 4'd3;
    end else begin
      r_state <= w_next;
      if (dc_upload_ack) begin
        r_buf <= dc_upload_flits;
        r_cnt <= 4'd0;
        r_len <= w_long ? 4'd9 : 4'd3;
      end else if (w_acc) begin
        r_cnt <= r_cnt + 4'd1;
`ifdef DC_UPLOAD_CLR_EN
        if (dc_upload_done) r_buf <= '0;
`else
`endif
      end
    end
  end

endmodule

// File: tb/tb_dc_upload.sv
// Scoreboard bench for dc_upload: stimulus pushes expected flits, a negedge monitor pops on each accepted flit.
module tb_dc_upload;

  logic         clk = 1'b0;
  logic         rst;
  logic         v_dc_upload;
  logic [143:0] dc_upload_flits;
  logic         OUT_fifo_rdy;
  logic         dc_upload_ack;
  logic         v_flit_out;
  logic [15:0]  flit_out;
  logic [1:0]   flit_ctrl_out;
  logic         dc_upload_done;
  logic [1:0]   dc_upload_state;

  dc_upload dut (
    .clk             (clk),
    .rst             (rst),
    .v_dc_upload     (v_dc_upload),
    .dc_upload_flits (dc_upload_flits),
    .OUT_fifo_rdy    (OUT_fifo_rdy),
    .dc_upload_ack   (dc_upload_ack),
    .v_flit_out      (v_flit_out),
    .flit_out        (flit_out),
    .flit_ctrl_out   (flit_ctrl_out),
    .dc_upload_done  (dc_upload_done),
    .dc_upload_state (dc_upload_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] f;
    logic [1:0]  c;
    logic        d;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted flit must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && v_flit_out === 1'b1) begin
      if (OUT_fifo_rdy) begin
        if (q.size() == 0) begin
          chk("unexpected_flit", {16'h0, flit_out}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("flit", {16'h0, flit_out}, {16'h0, e.f});
          chk("ctrl", {30'h0, flit_ctrl_out}, {30'h0, e.c});
          chk("done", {31'h0, dc_upload_done}, {31'h0, e.d});
        end
      end else begin
        chk("done_when_stalled", {31'h0, dc_upload_done}, 32'h0);
      end
    end
  end

  // Present a message, wait (bounded) for ack, push its flits, return after capture edge + 1.
  task automatic send(input logic [143:0] m, input int n, input bit keep_v);
    int  k;
    bit  got;
    exp_t e;
    dc_upload_flits = m;
    v_dc_upload     = 1'b1;
    #1;
    got = dc_upload_ack;
    k   = 0;
    while (!got && k < 50) begin
      @(negedge clk);
      got = dc_upload_ack;
      k++;
    end
    chk("ack_seen", {31'h0, got}, 32'h1);
    for (int i = 0; i < n; i++) begin
      e.f = m[16*i +: 16];
      e.c = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b11 : 2'b10);
      e.d = (i == n - 1);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep_v) v_dc_upload = 1'b0;
  endtask

  task automatic wait_idle(output int busy_cycles);
    int k;
    busy_cycles = 0;
    k = 0;
    @(negedge clk);
    while (dc_upload_state != 2'b00 && k < 200) begin
      busy_cycles++;
      k++;
      @(negedge clk);
    end
    if (k >= 200) chk("idle_timeout", 32'h1, 32'h0);
  endtask

  logic [143:0] m_short, m_long, m_at, m_b;
  int           n;
  logic [15:0]  idle_exp;

  initial begin
    m_short = '0;
    m_short[47:0] = {16'h5678, 16'h1234, 16'h0040};
    m_long = '0;
    for (int i = 0; i < 9; i++) m_long[16*i +: 16] = 16'h0200 + 16'(i);
    m_at = '0;
    for (int i = 0; i < 9; i++) m_at[16*i +: 16] = (i == 0) ? 16'h0260 : 16'h3000 + 16'(i);
    m_b = '0;
    m_b[47:0] = {16'hBBBB, 16'hAAAA, 16'h0220};
`ifdef DC_UPLOAD_CLR_EN
    idle_exp = 16'h0000;
`else
    idle_exp = 16'h0040;
`endif

    // Reset: all outputs 0 even with a message presented.
    rst = 1'b0;
    v_dc_upload = 1'b1;
    dc_upload_flits = m_long;
    OUT_fifo_rdy = 1'b1;
    #3;
    chk("rst_ack", {31'h0, dc_upload_ack}, 32'h0);
    chk("rst_state", {30'h0, dc_upload_state}, 32'h0);
    chk("rst_vld", {31'h0, v_flit_out}, 32'h0);
    chk("rst_flit", {16'h0, flit_out}, 32'h0);
    chk("rst_ctrl", {30'h0, flit_ctrl_out}, 32'h0);
    chk("rst_done", {31'h0, dc_upload_done}, 32'h0);
    @(posedge clk);
    #1;
    v_dc_upload = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Short message, rdy held high.
    send(m_short, 3, 1'b0);
    chk("short_first_vld", {31'h0, v_flit_out}, 32'h1);
    chk("short_first_ctrl", {30'h0, flit_ctrl_out}, 32'h1);
    chk("short_state_busy", {30'h0, dc_upload_state}, 32'h1);
    wait_idle(n);
    chk("short_cycles", n, 3);
    chk("idle_flit", {16'h0, flit_out}, {16'h0, idle_exp});
    chk("idle_ctrl", {30'h0, flit_ctrl_out}, 32'h0);
    chk("idle_vld", {31'h0, v_flit_out}, 32'h0);

    // Long write-back reply.
    @(posedge clk);
    #1;
    send(m_long, 9, 1'b0);
    wait_idle(n);
    chk("long_cycles", n, 9);

    // Backpressure on the second flit.
    @(posedge clk);
    #1;
    send(m_short, 3, 1'b0);
    @(posedge clk);
    #1;
    OUT_fifo_rdy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_flit", {16'h0, flit_out}, 32'h1234);
      chk("bp_ctrl", {30'h0, flit_ctrl_out}, 32'h2);
      chk("bp_vld", {31'h0, v_flit_out}, 32'h1);
    end
    @(posedge clk);
    #1;
    OUT_fifo_rdy = 1'b1;
    wait_idle(n);
    chk("bp_rest_cycles", n, 2);

    // Request held while busy: ignored, then captured on first idle cycle.
    @(posedge clk);
    #1;
    send(m_at, 9, 1'b1);
    dc_upload_flits = m_b;
    n = 0;
    @(negedge clk);
    while (dc_upload_state != 2'b00 && n < 50) begin
      chk("busy_ack", {31'h0, dc_upload_ack}, 32'h0);
      n++;
      @(negedge clk);
    end
    chk("first_idle_ack", {31'h0, dc_upload_ack}, 32'h1);
    send(m_b, 3, 1'b0);
    wait_idle(n);
    chk("b_cycles", n, 3);

    // Reset mid-transfer after five flits.
    @(posedge clk);
    #1;
    send(m_long, 9, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_vld", {31'h0, v_flit_out}, 32'h0);
    chk("midrst_state", {30'h0, dc_upload_state}, 32'h0);
    chk("midrst_flit", {16'h0, flit_out}, 32'h0);
    chk("midrst_left", q.size(), 4);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_vld", {31'h0, v_flit_out}, 32'h0);
      chk("post_rst_done", {31'h0, dc_upload_done}, 32'h0);
    end

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
